datapath_unit: RTL and testbench
================================

// Module: datapath_unit
// PURPOSE
//   Register-transfer datapath driven by the control unit's per-cycle control word. It holds the registers
//   AR, PC, DR, IR, R, TR, AC, R1, R2, Ri, Rj and Rk, a shared 16-source bus mux, the ALU and the zero flag.
//   It drives the instruction/data memory ports and returns ir and z to the control unit.
//   It also latches completion (done) and counts execution cycles for benchmarking matrix runs.
// PARAMETERS
//   DATA_W  8   width of every register, bus, ALU and memory data
//   ADDR_W  8   memory address width (low ADDR_W bits of AR / PC)
//   CNT_W   16  width of cycle counter
// PORTS
//   clk         in   1        rising-edge clock
//   rst         in   1        asynchronous, active-high reset
//   write_en    in   13       load strobes [12]ARB [11]AR [10]PC [9]DR [8]IR [7]R [6]TR [5]AC [4]R1 [3]R2 [2]Ri [1]Rj [0]Rk
//   bus_ld      in   4        bus source select (see BEHAVIOUR)
//   inc         in   2        [0] PC+1, [1] AC+1
//   clr         in   3        [2] AC, [1] TR, [0] PC synchronous clear
//   alu_mode    in   4        ALU operation for AC load
//   dm_wr       in   1        data-memory write strobe
//   im_wr       in   1        instruction-memory write strobe
//   end_op      in   1        program-end pulse
//   imem_rdata  in   DATA_W   instruction-memory read data
//   dmem_rdata  in   DATA_W   data-memory read data
//   imem_addr   out  ADDR_W   = PC
//   imem_wdata  out  DATA_W   = bus
//   imem_we     out  1        = im_wr
//   dmem_addr   out  ADDR_W   = AR
//   dmem_wdata  out  DATA_W   = bus
//   dmem_we     out  1        = dm_wr
//   ir          out  8        = IR[7:0], zero-extended if DATA_W<8
//   z           out  1        = (AC == 0), combinational from the AC register
//   done        out  1        sticky completion flag
//   cycle_count out  CNT_W    cycles since reset, frozen when done
// BEHAVIOUR
// - Reset (async):
//   - Every register, done and cycle_count go to 0.
//   - Therefore z=1, imem_addr=0, dmem_addr=0 and ir=0.
// - Bus mux (combinational), selected by bus_ld:
//   - 0 imem_rdata, 1 dmem_rdata, 2 PC, 3 DR, 4 R, 5 AC
//   - 6 TR, 7 R1, 8 R2, 9 Ri, 10 Rj, 11 Rk
//   - 12-15 drive 0.
// - Register loads: all registers update on posedge clk, one-cycle latency.
//   - Every register except AC and PC loads the bus when its write_en bit is set.
//   - ARB (bit 12) loads PC from the bus (branch target). Bits 12 and 10 are the same action.
//   - Several write_en bits set together load all the targeted registers in the same edge.
// - ALU (combinational, result truncated to DATA_W bits):
//   - 0 ADD AC+bus, 1 SUB AC-bus (modulo 2^DATA_W), 2 MUL low DATA_W bits of AC*bus.
//   - 5 PASS bus; all other modes pass AC unchanged.
//   - alu_mode is sampled only on AC load.
// - AC priority, highest first: clr[2] -> 0; write_en[5] -> ALU result; inc[1] -> AC+1 (wraps all-ones->0); else hold.
// - PC priority, highest first: clr[0] -> 0; write_en[12]|write_en[10] -> bus; inc[0] -> PC+1 (wraps); else hold.
// - TR priority: clr[1] -> 0 wins over write_en[6].
// - Memory ports:
//   - dmem_we and imem_we are combinational pass-through of dm_wr and im_wr; write data is the current bus.
//   - Reads are used on the bus in the same cycle; the control unit schedules memory latency.
// - done: set on the first clk edge with end_op=1, stays 1 until rst. While done=1:
//   - all register loads, inc and clr are ignored;
//   - memory write strobes are forced to 0.
// - cycle_count:
//   - Increments every clk edge while done=0, including the edge that sets done.
//   - Saturates at all-ones (no wrap) and holds when done=1.
// - Reset asserted mid-operation clears all state immediately, regardless of clk.
// TESTING
// - Reset check: assert rst mid-cycle -> all registers, cycle_count and done = 0, z=1, outputs 0, with no clk edge needed.
// - ADD: AC=5, R1=3, bus_ld=7, alu_mode=0, write_en[5] -> AC=8 next edge.
//   - Same with alu_mode=1 and AC=3, R1=5 -> AC=0xFE, z=0.
// - MUL/wrap: AC=0x20, Rk=0x10, bus_ld=11, alu_mode=2 -> AC=0x00, z=1.
//   - Then inc[1] with AC=0xFF -> AC=0x00.
// - Priority: clr=3'b111 with write_en[5]/[6]/[10] and inc=2'b11 all set -> AC=TR=PC=0.
//   - write_en[10] with inc[0] and bus=0x40 -> PC=0x40.
// - Memory path: AR=0x12, bus_ld=6 with TR=0x7A, dm_wr=1 -> dmem_addr=0x12, dmem_wdata=0x7A, dmem_we=1 the same cycle.
// - End: end_op pulse after 37 cycles -> done=1, cycle_count=37 and frozen; later write_en/dm_wr are ignored.
//   - Separately, force cycle_count to saturate -> it holds at 0xFFFF.

Source files
------------

// File: rtl/datapath_unit_if.sv
// Control-word and memory-port bundle between the control unit / memories and datapath_unit.
// The master side drives the control word and memory read data; the slave side is the datapath.
interface datapath_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic [12:0]       write_en;
    logic [3:0]        bus_ld;
    logic [1:0]        inc;
    logic [2:0]        clr;
    logic [3:0]        alu_mode;
    logic              dm_wr;
    logic              im_wr;
    logic              end_op;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              imem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_we;
    logic [7:0]        ir;
    logic              z;
    logic              done;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        output write_en, bus_ld, inc, clr, alu_mode, dm_wr, im_wr, end_op,
        output imem_rdata, dmem_rdata,
        input  imem_addr, imem_wdata, imem_we, dmem_addr, dmem_wdata, dmem_we,
        input  ir, z, done, cycle_count
    );

    modport slave (
        input  write_en, bus_ld, inc, clr, alu_mode, dm_wr, im_wr, end_op,
        input  imem_rdata, dmem_rdata,
        output imem_addr, imem_wdata, imem_we, dmem_addr, dmem_wdata, dmem_we,
        output ir, z, done, cycle_count
    );
endinterface

// File: rtl/datapath_unit.sv
// Register-transfer datapath: register set, shared bus mux, ALU, zero flag, memory ports,
// sticky completion flag and a saturating execution-cycle counter.
module datapath_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst,
    datapath_unit_if.slave dp
);

    logic [DATA_W-1:0] ar, pc, dr, ir_reg, r, tr, ac, r1, r2, ri, rj, rk;
    logic [DATA_W-1:0] bus, alu_res;
    logic              done;
    logic [CNT_W-1:0]  cycle_count;

    always_comb begin
        case (dp.bus_ld)
            4'd0:    bus = dp.imem_rdata;
            4'd1:    bus = dp.dmem_rdata;
            4'd2:    bus = pc;
            4'd3:    bus = dr;
            4'd4:    bus = r;
            4'd5:    bus = ac;
            4'd6:    bus = tr;
            4'd7:    bus = r1;
            4'd8:    bus = r2;
            4'd9:    bus = ri;
            4'd10:   bus = rj;
            4'd11:   bus = rk;
            default: bus = '0;
        endcase
    end

    always_comb begin
        case (dp.alu_mode)
            4'd0:    alu_res = ac + bus;
            4'd1:    alu_res = ac - bus;
            4'd2:    alu_res = ac * bus;
            4'd5:    alu_res = bus;
            default: alu_res = ac;
        endcase
    end

    // Once done is set the whole datapath freezes until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar     <= '0;
            pc     <= '0;
            dr     <= '0;
            ir_reg <= '0;
            r      <= '0;
            tr     <= '0;
            ac     <= '0;
            r1     <= '0;
            r2     <= '0;
            ri     <= '0;
            rj     <= '0;
            rk     <= '0;
        end else if (!done) begin
            if (dp.write_en[11]) ar     <= bus;
            if (dp.write_en[9])  dr     <= bus;
            if (dp.write_en[8])  ir_reg <= bus;
            if (dp.write_en[7])  r      <= bus;
            if (dp.write_en[4])  r1     <= bus;
            if (dp.write_en[3])  r2     <= bus;
            if (dp.write_en[2])  ri     <= bus;
            if (dp.write_en[1])  rj     <= bus;
            if (dp.write_en[0])  rk     <= bus;

            if (dp.clr[1])            tr <= '0;
            else if (dp.write_en[6])  tr <= bus;

            if (dp.clr[2])            ac <= '0;
            else if (dp.write_en[5])  ac <= alu_res;
            else if (dp.inc[1])       ac <= ac + DATA_W'(1);

            // Branch target load (ARB) and plain PC load are the same action.
            if (dp.clr[0])                            pc <= '0;
            else if (dp.write_en[12] || dp.write_en[10]) pc <= bus;
            else if (dp.inc[0])                       pc <= pc + DATA_W'(1);
        end
    end

    // The edge that sees end_op still counts, so the count includes the final cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done        <= 1'b0;
            cycle_count <= '0;
        end else if (!done) begin
            if (dp.end_op) done <= 1'b1;
            if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    assign dp.imem_addr   = ADDR_W'(pc);
    assign dp.dmem_addr   = ADDR_W'(ar);
    assign dp.imem_wdata  = bus;
    assign dp.dmem_wdata  = bus;
    assign dp.imem_we     = dp.im_wr & ~done;
    assign dp.dmem_we     = dp.dm_wr & ~done;
    assign dp.ir          = 8'(ir_reg);
    assign dp.z           = (ac == '0);
    assign dp.done        = done;
    assign dp.cycle_count = cycle_count;

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: directed scenarios with literal expectations plus
// randomized control words checked every cycle against a table-driven register-transfer model.
module tb_datapath_unit;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 8;
    // Bus source per bus_ld value: -1 imem, -2 dmem, -3 zero, otherwise the write_en bit of that register.
    localparam int BUS_SRC [0:15] = '{-1, -2, 10, 9, 7, 5, 6, 4, 3, 2, 1, 0, -3, -3, -3, -3};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_sat = 1'b0;
    int   total = 0;
    int   bad = 0;

    datapath_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dp_if();
    datapath_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(SAT_W)) sat_if();

    datapath_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .dp(dp_if)
    );
    datapath_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst_sat), .dp(sat_if)
    );

    always #5 clk = ~clk;

    logic [7:0] m_reg [0:12];
    logic       m_done;
    int         m_count;
    logic [7:0] m_bus, m_alu;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] modelBus();
        int s;
        s = BUS_SRC[dp_if.bus_ld];
        if (s == -1) return dp_if.imem_rdata;
        if (s == -2) return dp_if.dmem_rdata;
        if (s < 0) return 8'h00;
        return m_reg[s];
    endfunction

    function automatic logic [7:0] modelAlu(input int mode, input int a, input int b);
        int res;
        case (mode)
            0:       res = a + b;
            1:       res = a - b;
            2:       res = a * b;
            5:       res = b;
            default: res = a;
        endcase
        return 8'(res & 255);
    endfunction

    // Reference model: registers indexed by their write_en bit, PC at 10, AC at 5.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 13; i++) m_reg[i] = 8'h00;
            m_done  = 1'b0;
            m_count = 0;
        end else if (!m_done) begin
            m_bus = modelBus();
            m_alu = modelAlu(int'(dp_if.alu_mode), int'(m_reg[5]), int'(m_bus));
            for (int i = 0; i < 12; i++)
                if (i != 5 && i != 10 && i != 6 && dp_if.write_en[i]) m_reg[i] = m_bus;
            if (dp_if.clr[1])           m_reg[6] = 8'h00;
            else if (dp_if.write_en[6]) m_reg[6] = m_bus;
            if (dp_if.clr[2])           m_reg[5] = 8'h00;
            else if (dp_if.write_en[5]) m_reg[5] = m_alu;
            else if (dp_if.inc[1])      m_reg[5] = 8'((int'(m_reg[5]) + 1) % 256);
            if (dp_if.clr[0])           m_reg[10] = 8'h00;
            else if (dp_if.write_en[12] || dp_if.write_en[10]) m_reg[10] = m_bus;
            else if (dp_if.inc[0])      m_reg[10] = 8'((int'(m_reg[10]) + 1) % 256);
            if (m_count < 65535) m_count = m_count + 1;
            if (dp_if.end_op) m_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        checkOutput("imem_addr", 32'(dp_if.imem_addr), 32'(m_reg[10]));
        checkOutput("dmem_addr", 32'(dp_if.dmem_addr), 32'(m_reg[11]));
        checkOutput("ir", 32'(dp_if.ir), 32'(m_reg[8]));
        checkOutput("z", 32'(dp_if.z), 32'(m_reg[5] == 8'h00));
        checkOutput("done", 32'(dp_if.done), 32'(m_done));
        checkOutput("cycle_count", 32'(dp_if.cycle_count), 32'(m_count));
        checkOutput("dmem_wdata", 32'(dp_if.dmem_wdata), 32'(modelBus()));
        checkOutput("imem_wdata", 32'(dp_if.imem_wdata), 32'(modelBus()));
        checkOutput("dmem_we", 32'(dp_if.dmem_we), 32'(dp_if.dm_wr & ~m_done));
        checkOutput("imem_we", 32'(dp_if.imem_we), 32'(dp_if.im_wr & ~m_done));
    end

    task automatic applyStimulus(input logic [12:0] we, input logic [3:0] bl, input logic [1:0] inc_v,
                                 input logic [2:0] clr_v, input logic [3:0] am, input logic dm,
                                 input logic im, input logic eo, input logic [7:0] ird,
                                 input logic [7:0] drd);
        dp_if.write_en   = we;
        dp_if.bus_ld     = bl;
        dp_if.inc        = inc_v;
        dp_if.clr        = clr_v;
        dp_if.alu_mode   = am;
        dp_if.dm_wr      = dm;
        dp_if.im_wr      = im;
        dp_if.end_op     = eo;
        dp_if.imem_rdata = ird;
        dp_if.dmem_rdata = drd;
        @(posedge clk);
        #2;
        dp_if.write_en = '0;
        dp_if.inc      = '0;
        dp_if.clr      = '0;
        dp_if.dm_wr    = 1'b0;
        dp_if.im_wr    = 1'b0;
        dp_if.end_op   = 1'b0;
    endtask

    task automatic loadReg(input int bit_idx, input logic [7:0] val);
        applyStimulus(13'(1) << bit_idx, 4'd0, 2'b00, 3'b000, 4'd5, 1'b0, 1'b0, 1'b0, val, 8'h00);
    endtask

    task automatic peekBus(input string name, input logic [3:0] sel, input logic [7:0] exp);
        dp_if.bus_ld = sel;
        #1;
        checkOutput(name, 32'(dp_if.dmem_wdata), 32'(exp));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_count"}, 32'(dp_if.cycle_count), 32'h0);
        checkOutput({tag, "_done"}, 32'(dp_if.done), 32'h0);
        checkOutput({tag, "_z"}, 32'(dp_if.z), 32'h1);
        checkOutput({tag, "_imem_addr"}, 32'(dp_if.imem_addr), 32'h0);
        checkOutput({tag, "_dmem_addr"}, 32'(dp_if.dmem_addr), 32'h0);
        checkOutput({tag, "_ir"}, 32'(dp_if.ir), 32'h0);
    endtask

    initial begin
        dp_if.write_en = '0; dp_if.bus_ld = '0; dp_if.inc = '0; dp_if.clr = '0;
        dp_if.alu_mode = '0; dp_if.dm_wr = 1'b0; dp_if.im_wr = 1'b0; dp_if.end_op = 1'b0;
        dp_if.imem_rdata = '0; dp_if.dmem_rdata = '0;
        sat_if.write_en = '0; sat_if.bus_ld = '0; sat_if.inc = '0; sat_if.clr = '0;
        sat_if.alu_mode = '0; sat_if.dm_wr = 1'b0; sat_if.im_wr = 1'b0; sat_if.end_op = 1'b0;
        sat_if.imem_rdata = '0; sat_if.dmem_rdata = '0;
        #1;
        rst = 1'b1;
        rst_sat = 1'b1;
        #1;
        checkResetState("init");
        @(posedge clk);
        #2;
        rst = 1'b0;
        rst_sat = 1'b0;

        // ADD, SUB, MUL wrap and AC increment wrap
        loadReg(5, 8'd5);
        loadReg(4, 8'd3);
        applyStimulus(13'h0020, 4'd7, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        peekBus("add_ac", 4'd5, 8'h08);
        checkOutput("add_z", 32'(dp_if.z), 32'h0);
        loadReg(5, 8'd3);
        loadReg(4, 8'd5);
        applyStimulus(13'h0020, 4'd7, 2'b00, 3'b000, 4'd1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        peekBus("sub_ac", 4'd5, 8'hFE);
        checkOutput("sub_z", 32'(dp_if.z), 32'h0);
        loadReg(5, 8'h20);
        loadReg(0, 8'h10);
        applyStimulus(13'h0020, 4'd11, 2'b00, 3'b000, 4'd2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        peekBus("mul_ac", 4'd5, 8'h00);
        checkOutput("mul_z", 32'(dp_if.z), 32'h1);
        loadReg(5, 8'hFF);
        checkOutput("ff_z", 32'(dp_if.z), 32'h0);
        applyStimulus(13'h0000, 4'd0, 2'b10, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("incwrap_z", 32'(dp_if.z), 32'h1);

        // Clear beats load and increment; load beats increment
        loadReg(5, 8'h11);
        loadReg(6, 8'h22);
        loadReg(10, 8'h33);
        checkOutput("pc_load", 32'(dp_if.imem_addr), 32'h33);
        applyStimulus(13'h0460, 4'd0, 2'b11, 3'b111, 4'd5, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00);
        checkOutput("prio_pc", 32'(dp_if.imem_addr), 32'h0);
        checkOutput("prio_z", 32'(dp_if.z), 32'h1);
        peekBus("prio_tr", 4'd6, 8'h00);
        applyStimulus(13'h0400, 4'd0, 2'b01, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'h40, 8'h00);
        checkOutput("pc_over_inc", 32'(dp_if.imem_addr), 32'h40);
        applyStimulus(13'h1000, 4'd0, 2'b01, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'h41, 8'h00);
        checkOutput("arb_load", 32'(dp_if.imem_addr), 32'h41);
        loadReg(8, 8'hA5);
        checkOutput("ir_load", 32'(dp_if.ir), 32'hA5);

        // Memory write path is visible in the same cycle
        loadReg(11, 8'h12);
        loadReg(6, 8'h7A);
        dp_if.bus_ld = 4'd6;
        dp_if.dm_wr = 1'b1;
        #1;
        checkOutput("mem_addr", 32'(dp_if.dmem_addr), 32'h12);
        checkOutput("mem_wdata", 32'(dp_if.dmem_wdata), 32'h7A);
        checkOutput("mem_we", 32'(dp_if.dmem_we), 32'h1);
        dp_if.dm_wr = 1'b0;

        for (int n = 0; n < 400; n++) begin
            applyStimulus(13'($urandom), 4'($urandom), 2'($urandom),
                          ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000,
                          4'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                          8'($urandom), 8'($urandom));
        end

        // Asynchronous reset in the middle of a cycle
        #1;
        rst = 1'b1;
        #1;
        checkResetState("midrst");
        for (int s = 2; s < 12; s++) peekBus("midrst_bus", 4'(s), 8'h00);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // end_op on the 37th edge after reset release freezes everything
        for (int n = 0; n < 36; n++)
            applyStimulus(13'h0000, 4'd0, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("pre_end_count", 32'(dp_if.cycle_count), 32'd36);
        checkOutput("pre_end_done", 32'(dp_if.done), 32'h0);
        applyStimulus(13'h0000, 4'd0, 2'b00, 3'b000, 4'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        checkOutput("end_count", 32'(dp_if.cycle_count), 32'd37);
        checkOutput("end_done", 32'(dp_if.done), 32'h1);
        for (int n = 0; n < 5; n++)
            applyStimulus(13'h1FFF, 4'd0, 2'b11, 3'b000, 4'd5, 1'b1, 1'b1, 1'b0, 8'h99, 8'h00);
        dp_if.dm_wr = 1'b1;
        dp_if.im_wr = 1'b1;
        #1;
        checkOutput("frozen_count", 32'(dp_if.cycle_count), 32'd37);
        checkOutput("frozen_done", 32'(dp_if.done), 32'h1);
        checkOutput("frozen_pc", 32'(dp_if.imem_addr), 32'h0);
        checkOutput("frozen_ir", 32'(dp_if.ir), 32'h0);
        checkOutput("frozen_dmem_we", 32'(dp_if.dmem_we), 32'h0);
        checkOutput("frozen_imem_we", 32'(dp_if.imem_we), 32'h0);
        dp_if.dm_wr = 1'b0;
        dp_if.im_wr = 1'b0;

        // The narrow-counter instance has been running since the start and must sit at all-ones
        checkOutput("sat_count", 32'(sat_if.cycle_count), 32'hFF);
        @(posedge clk);
        #2;
        checkOutput("sat_hold", 32'(sat_if.cycle_count), 32'hFF);
        checkOutput("sat_done", 32'(sat_if.done), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
